fir_decim_requant: RTL and testbench
====================================

Name: fir_decim_requant

Overview:
- Downstream stage of the 32-tap FIR low-pass filter.
- Consumes the filter's 32-bit signed accumulator output and decimates it by DECIM.
- Rounds and rescales the result to 16-bit signed with saturation.
- Buffers the result in a small FIFO with a valid/ready interface toward the sample sink (packetiser/DMA).
- Also reports saturation and overflow events.

Parameters:
- DECIM, 4: decimation factor; one of every DECIM accepted input samples is kept; legal range 1..256.
- SHIFT, 14: arithmetic right-shift applied after rounding; removes FIR coefficient gain; legal range 1..16.
- DEPTH, 8: output FIFO depth in samples; power of 2, ≥2.

Ports:
- clk, in, 1: system clock, all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: in_data holds a new filter output this cycle (tie high when the filter runs every clk).
- in_data, in, 32: signed FIR accumulator output.
- out_valid, out, 1: FIFO head holds a sample.
- out_ready, in, 1: sink accepts the head sample this cycle.
- out_data, out, 16: signed requantised sample (FIFO head).
- fifo_level, out, $clog2(DEPTH)+1: number of samples held.
- sat_pulse, out, 1: one-cycle pulse when a kept sample was clipped.
- overflow, out, 1: sticky; a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge):
  - decimation counter ← 0; pipeline valid bits ← 0; FIFO pointers ← 0.
  - out_valid=0, out_data=0, fifo_level=0, sat_pulse=0, overflow=0.
  - Reset mid-operation discards all in-flight and buffered samples. No output until new input arrives.
- Decimation:
  - Counter cnt is 0..DECIM-1 and advances only on in_valid; it wraps from DECIM-1 to 0.
  - A sample is kept when in_valid=1 and cnt==0, so the first accepted sample after reset is kept.
  - DECIM=1 keeps every sample.
  - in_valid=0 holds cnt.
- Stage 1 (register at edge k+1 for a sample kept at edge k):
  - r = (sign-extend in_data to 34 bits + 2^(SHIFT-1)) >>> SHIFT.
  - Rounding is round-half-up toward +inf; the shift is arithmetic.
- Stage 2 (edge k+2):
  - Saturate r to [-32768, 32767] and push the result into the FIFO.
  - sat_pulse=1 during the cycle after edge k+2 if clipping occurred; otherwise 0.
- Latency:
  - A kept sample accepted at edge k is visible at the FIFO head (out_valid=1) from edge k+2 when the FIFO was empty.
  - There is no combinational input-to-output path.
- FIFO:
  - out_data and out_valid are driven from the head register/memory; out_valid = (fifo_level != 0).
  - Pop occurs when out_valid && out_ready at a clk edge; out_data must stay stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle: both occur and fifo_level is unchanged. This is allowed at full and at level 1.
  - Push when empty with out_ready=1: the sample is not bypassed; it pops at the earliest on the following edge.
  - Push when full with no simultaneous pop: the sample is dropped and overflow ← 1. overflow is held until rst.
  - Pointers wrap modulo DEPTH; fifo_level never exceeds DEPTH.
- The stage-1/2 pipeline never stalls; backpressure is absorbed solely by the FIFO and reported via overflow.

Test Plan:
- Rounding/scaling (DECIM=1, SHIFT=14):
  - in_data 16384 → out_data 1.
  - 8192 → 1 (half rounds up).
  - -8192 → 0.
  - -8193 → -1.
  - First result has out_valid high 2 edges after the input edge.
- Saturation:
  - in_data 0x7FFFFFFF → 32767 with sat_pulse=1.
  - 0x80000000 → -32768 with sat_pulse=1.
  - 536854528 (=32767·16384) → 32767 with sat_pulse=0.
- Decimation (DECIM=4, out_ready=1):
  - Continuous in_valid with in_data = n·16384 for n=0..11 → outputs 0, 4, 8 only.
  - Repeat with in_valid deasserted every other cycle → same outputs.
- Backpressure/overflow (DECIM=1, DEPTH=8, out_ready=0):
  - Push 10 samples 1..10 → fifo_level=8, overflow=1.
  - Raise out_ready → pops 1..8 in order, then out_valid=0; overflow stays 1.
- Simultaneous push/pop at full:
  - Hold the FIFO full and assert out_ready while a kept sample arrives → fifo_level stays 8, no drop, overflow stays 0.
- Reset mid-operation:
  - Assert rst for 1 cycle with fifo_level=5 and 2 samples in the pipeline → next cycle fifo_level=0, out_valid=0, overflow=0.
  - First kept sample after reset is the first in_valid sample.

Source files
------------

// File: rtl/fir_decim_requant.sv
// Decimates the FIR accumulator stream, rounds/rescales to 16-bit signed with saturation,
// and buffers results in a small FIFO toward the sample sink.
module fir_decim_requant #(
  parameter int DECIM = 4,
  parameter int SHIFT = 14,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     sat_pulse,
  output logic                     overflow
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DECIM - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]       LVL_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]       LVL_FULL  = (PTR_W + 1)'(DEPTH);
  localparam logic signed [33:0]   ROUND     = 34'sd1 <<< (SHIFT - 1);
  localparam logic signed [33:0]   SAT_MAX   = 34'sd32767;
  localparam logic signed [33:0]   SAT_MIN   = -34'sd32768;

  logic [CNT_W-1:0]        cnt_reg;
  logic                    keep;
  logic                    in_valid_reg;
  logic [31:0]             in_data_reg;
  logic signed [33:0]      ext;
  logic signed [33:0]      rnd;
  logic                    s1_valid_reg;
  logic signed [33:0]      s1_r_reg;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [15:0]             sat_val;
  logic [15:0]             mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [PTR_W:0]          level_reg;
  logic                    full;
  logic                    do_pop;
  logic                    do_push;
  logic                    sat_pulse_reg;
  logic                    overflow_reg;

  assign keep = in_valid && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (in_valid) begin
      cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_ONE;
    end
  end

  // Input capture stage: only kept samples are flagged valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_reg <= 1'b0;
      in_data_reg  <= '0;
    end else begin
      in_valid_reg <= keep;
      if (keep) in_data_reg <= in_data;
    end
  end

  // 34 bits hold the full-scale input plus the rounding offset without wrap.
  assign ext = 34'(signed'(in_data_reg));
  assign rnd = (ext + ROUND) >>> SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_r_reg     <= '0;
    end else begin
      s1_valid_reg <= in_valid_reg;
      if (in_valid_reg) s1_r_reg <= rnd;
    end
  end

  assign sat_hi  = s1_r_reg > SAT_MAX;
  assign sat_lo  = s1_r_reg < SAT_MIN;
  assign sat_val = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : s1_r_reg[15:0]);

  assign full    = (level_reg == LVL_FULL);
  assign do_pop  = out_valid && out_ready;
  assign do_push = s1_valid_reg && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      sat_pulse_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
      sat_pulse_reg <= s1_valid_reg && (sat_hi || sat_lo);
      if (s1_valid_reg && full && !do_pop) overflow_reg <= 1'b1;
    end
  end

  // Head is gated so stale memory never shows while the FIFO is empty.
  assign out_valid  = (level_reg != '0);
  assign out_data   = out_valid ? mem[rd_ptr_reg] : 16'h0000;
  assign fifo_level = level_reg;
  assign sat_pulse  = sat_pulse_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench for fir_decim_requant: one DECIM=1 and one DECIM=4 instance on shared stimulus.
module tb_fir_decim_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        ov1, sat1, of1;
  logic [15:0] od1;
  logic [3:0]  lvl1;
  logic        ov4, sat4, of4;
  logic [15:0] od4;
  logic [3:0]  lvl4;

  int checks = 0;
  int failures = 0;
  int q[$];

  always #5 clk = ~clk;

  fir_decim_requant #(.DECIM(1), .SHIFT(14), .DEPTH(8)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .fifo_level(lvl1), .sat_pulse(sat1), .overflow(of1)
  );

  fir_decim_requant #(.DECIM(4), .SHIFT(14), .DEPTH(8)) dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .fifo_level(lvl4), .sat_pulse(sat4), .overflow(of4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rec4();
    if (ov4) q.push_back(int'($signed(od4)));
  endtask

  task automatic push_val(input int v);
    in_valid = 1'b1;
    in_data = 32'(v * 16384);
    tick();
  endtask

  // One DECIM=1 sample through the pipeline with out_ready high.
  task automatic send_one(input string tag, input logic [31:0] data, input int exp, input int exp_sat);
    in_valid = 1'b1;
    in_data = data;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_latency_valid"}, int'(ov1), 0);
    tick();
    chk({tag, "_valid"}, int'(ov1), 1);
    chk({tag, "_data"}, int'($signed(od1)), exp);
    chk({tag, "_sat"}, int'(sat1), exp_sat);
    tick();
    chk({tag, "_drained"}, int'(lvl1), 0);
    chk({tag, "_sat_clear"}, int'(sat1), 0);
  endtask

  function automatic int qget(input int i);
    return (q.size() > i) ? q[i] : -99999;
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_valid", int'(ov1), 0);
    chk("reset_data", int'(od1), 0);
    chk("reset_level", int'(lvl1), 0);
    chk("reset_sat", int'(sat1), 0);
    chk("reset_overflow", int'(of1), 0);
    rst = 1'b0;

    // Rounding and saturation
    out_ready = 1'b1;
    send_one("round_16384", 32'd16384, 1, 0);
    send_one("round_half", 32'd8192, 1, 0);
    send_one("round_m8192", -32'sd8192, 0, 0);
    send_one("round_m8193", -32'sd8193, -1, 0);
    send_one("sat_pos", 32'h7FFF_FFFF, 32767, 1);
    send_one("sat_neg", 32'h8000_0000, -32768, 1);
    send_one("max_nosat", 32'd536854528, 32767, 0);

    // Decimation by 4, continuous input
    do_reset();
    out_ready = 1'b1;
    q.delete();
    for (int n = 0; n < 12; n++) begin
      push_val(n);
      rec4();
    end
    in_valid = 1'b0;
    repeat (4) begin
      tick();
      rec4();
    end
    chk("decim_cont_count", q.size(), 3);
    chk("decim_cont_0", qget(0), 0);
    chk("decim_cont_1", qget(1), 4);
    chk("decim_cont_2", qget(2), 8);

    // Decimation with in_valid gaps
    do_reset();
    q.delete();
    for (int i = 0; i < 24; i++) begin
      in_valid = (i % 2 == 0);
      in_data = 32'((i / 2) * 16384);
      tick();
      rec4();
    end
    in_valid = 1'b0;
    repeat (4) begin
      tick();
      rec4();
    end
    chk("decim_gap_count", q.size(), 3);
    chk("decim_gap_0", qget(0), 0);
    chk("decim_gap_1", qget(1), 4);
    chk("decim_gap_2", qget(2), 8);

    // Backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 10; v++) push_val(v);
    in_valid = 1'b0;
    tick();
    tick();
    chk("ovf_level", int'(lvl1), 8);
    chk("ovf_flag", int'(of1), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d_valid", i), int'(ov1), 1);
      chk($sformatf("ovf_pop%0d_data", i), int'($signed(od1)), i);
      tick();
    end
    chk("ovf_empty_valid", int'(ov1), 0);
    chk("ovf_sticky", int'(of1), 1);

    // Simultaneous push and pop at full
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 8; v++) push_val(v);
    in_valid = 1'b0;
    tick();
    tick();
    chk("full_level", int'(lvl1), 8);
    chk("full_no_ovf", int'(of1), 0);
    push_val(9);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pushpop_level", int'(lvl1), 8);
    chk("pushpop_no_ovf", int'(of1), 0);
    chk("pushpop_head", int'($signed(od1)), 2);
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("pushpop_drain%0d", i), int'($signed(od1)), i);
      tick();
    end
    chk("pushpop_empty", int'(ov1), 0);

    // Reset mid-operation
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 7; v++) push_val(v);
    in_valid = 1'b0;
    chk("midrst_pre_level", int'(lvl1), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_level", int'(lvl1), 0);
    chk("midrst_valid", int'(ov1), 0);
    chk("midrst_data", int'(od1), 0);
    chk("midrst_overflow", int'(of1), 0);
    chk("midrst_level_d4", int'(lvl4), 0);
    repeat (3) tick();
    chk("midrst_flushed_d1", int'(lvl1), 0);
    chk("midrst_flushed_d4", int'(lvl4), 0);
    for (int v = 5; v <= 8; v++) push_val(v);
    in_valid = 1'b0;
    tick();
    tick();
    chk("midrst_first_d4_level", int'(lvl4), 1);
    chk("midrst_first_d4_data", int'($signed(od4)), 5);
    chk("midrst_first_d1_level", int'(lvl1), 4);
    chk("midrst_first_d1_data", int'($signed(od1)), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
